// File: rtl/fifo8_pair_reader.sv
// fifo8_pair_reader: pops two words from the 8-deep FIFO and presents them
// as an (op_a, op_b) operand pair on a valid/ready handshake. It also keeps
// a wrapping count of delivered pairs and a saturating count of aborted fetches.
module fifo8_pair_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] fifo_dout,
  input  logic [3:0]  fifo_count,
  input  logic        rd_ack,
  input  logic        rd_err,
  output logic        rd_en,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  pair_cnt,
  output logic [3:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP_A = 3'd1,
    CAP_A = 3'd2,
    CAP_B = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t state_reg;
  state_t state_next;

  // A response flagged as an error is never trusted, even if ack is also
  // set; a healthy FIFO never raises both, so this only hardens the FSM.
  logic ack_ok;
  logic cap_a;
  logic cap_b;
  logic fetch_fail;
  logic transfer;

  assign ack_ok = rd_ack & ~rd_err;

  // Next-state and pop-request decode; en and the occupancy threshold
  // only matter in IDLE, so a fetch in flight always runs to completion.
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    fetch_fail = 1'b0;
    transfer   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en && (fifo_count >= 4'd2)) state_next = POP_A;
      end
      POP_A: begin
        rd_en      = 1'b1;
        state_next = CAP_A;
      end
      CAP_A: begin
        if (ack_ok) begin
          // Capture A and pop B in the same cycle to keep the pair tight.
          rd_en      = 1'b1;
          cap_a      = 1'b1;
          state_next = CAP_B;
        end else begin
          fetch_fail = 1'b1;
          state_next = IDLE;
        end
      end
      CAP_B: begin
        if (ack_ok) begin
          cap_b      = 1'b1;
          state_next = HOLD;
        end else begin
          // Word A is already out of the FIFO and is dropped here.
          fetch_fail = 1'b1;
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          transfer   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Operand capture; the registers hold steady through HOLD back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a <= 32'd0;
      op_b <= 32'd0;
    end else begin
      if (cap_a) op_a <= fifo_dout;
      if (cap_b) op_b <= fifo_dout;
    end
  end

  // Statistics: pair count wraps, error count sticks at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_cnt <= 8'd0;
      err_cnt  <= 4'd0;
    end else begin
      if (transfer) pair_cnt <= pair_cnt + 8'd1;
      if (fetch_fail && (err_cnt != 4'hF)) err_cnt <= err_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_fifo8_pair_reader.sv
// Bench for fifo8_pair_reader: a behavioural FIFO feeds the reader, written
// words go into a scoreboard queue and are matched against delivered pairs.
module tb_fifo8_pair_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        out_ready;
  logic [31:0] fifo_dout = 32'd0;
  logic [3:0]  fifo_count = 4'd0;
  logic        rd_ack = 1'b0;
  logic        rd_err = 1'b0;
  logic        rd_en;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        busy;
  logic [7:0]  pair_cnt;
  logic [3:0]  err_cnt;

  // FIFO model controls
  logic        wr_en;
  logic [31:0] wr_data;
  logic        flush;
  logic        fail_is_err;
  int          fail_seq;
  int          rd_seq = 0;
  int          err_resp = 0;
  logic [31:0] fifo_q[$];

  // Scoreboard and statistics
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pairs_seen = 0;
  int          valid_cycles = 0;
  int          rd_run = 0;

  fifo8_pair_reader dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .fifo_dout  (fifo_dout),
    .fifo_count (fifo_count),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .rd_en      (rd_en),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .pair_cnt   (pair_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: a pop request in cycle N answers in cycle N+1; the response
  // with sequence number fail_seq is replaced by an error or by silence.
  always @(posedge clk) begin
    rd_ack <= 1'b0;
    rd_err <= 1'b0;
    if (flush) begin
      fifo_q.delete();
    end else begin
      if (rd_en) begin
        if (rd_seq == fail_seq) begin
          rd_err <= fail_is_err;
        end else if (fifo_q.size() == 0) begin
          rd_err   <= 1'b1;
          err_resp <= err_resp + 1;
        end else begin
          fifo_dout <= fifo_q.pop_front();
          rd_ack    <= 1'b1;
        end
        rd_seq <= rd_seq + 1;
      end
      if (wr_en) fifo_q.push_back(wr_data);
    end
    fifo_count <= 4'(fifo_q.size());
  end

  // Output monitor: pairs against the scoreboard, rd_en run length.
  always @(negedge clk) begin
    #1;
    if (rd_en) begin
      rd_run++;
      chk("rd_en_run_le2", 32'(rd_run <= 2), 32'd1);
    end else begin
      rd_run = 0;
    end
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready && !reset) begin
      if (exp_q.size() < 2) begin
        chk("sb_depth", 32'(exp_q.size()), 32'd2);
      end else begin
        logic [31:0] ea;
        logic [31:0] eb;
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        chk("pair_op_a", op_a, ea);
        chk("pair_op_b", op_b, eb);
      end
      pairs_seen++;
      $display("pair %0d: op_a=%08h op_b=%08h pair_cnt_before=%0d", pairs_seen, op_a, op_b, pair_cnt);
    end
  end

  // One FIFO write per call; called and returns at a falling edge.
  task automatic write_word(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (busy !== lvl && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'(lvl));
  endtask

  task automatic wait_pairs(input int target, input int budget, input string tag);
    int n = 0;
    while (pairs_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(pairs_seen), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_hi;
    int busy_hi;
    int first_valid;
    int bad;
    int exp_err;
    int base;
    int e0;
    int vc0;
    int guard;
    logic [31:0] snap_a;
    logic [31:0] snap_b;
    logic [3:0]  snap_c;

    reset = 1'b1; flush = 1'b1; en = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_data = 32'd0; fail_is_err = 1'b0; fail_seq = -1;

    // Reset with random control inputs
    @(negedge clk);
    repeat (2) begin
      en = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
    end
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_pair_cnt", 32'(pair_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0; flush = 1'b0; en = 1'b0; out_ready = 1'b1;

    // Single pair: latency and rd_en width
    write_word(32'hA5A5_0001);
    write_word(32'h0000_00FF);
    chk("single_count2", 32'(fifo_count), 32'd2);
    en = 1'b1; rd_hi = 0; first_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rd_en) rd_hi++;
      if (out_valid && first_valid == 0) first_valid = k;
    end
    chk("single_rd_en_cycles", 32'(rd_hi), 32'd2);
    chk("single_latency", 32'(first_valid), 32'd4);
    chk("single_pair_cnt", 32'(pair_cnt), 32'd1);
    chk("single_fifo_empty", 32'(fifo_count), 32'd0);
    chk("single_pairs_seen", 32'(pairs_seen), 32'd1);

    // Threshold: one word is never enough
    write_word(32'h1111_2222);
    rd_hi = 0; busy_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_en) rd_hi++;
      if (busy) busy_hi++;
    end
    chk("thr_no_rd_en", 32'(rd_hi), 32'd0);
    chk("thr_not_busy", 32'(busy_hi), 32'd0);
    write_word(32'h3333_4444);
    @(negedge clk);
    chk("thr_fetch_start", 32'(rd_en), 32'd1);
    wait_pairs(2, 20, "thr_pair_done");
    chk("thr_pair_cnt", 32'(pair_cnt), 32'd2);

    // Back-pressure in HOLD
    out_ready = 1'b0;
    write_word(32'hB000_0001);
    write_word(32'hB000_0002);
    write_word(32'hB000_0003);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    snap_a = op_a; snap_b = op_b; snap_c = fifo_count; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (op_a !== snap_a || op_b !== snap_b) bad++;
      if (rd_en || !out_valid || fifo_count !== snap_c) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_fifo_count", 32'(fifo_count), 32'd1);
    chk("bp_pair_cnt_held", 32'(pair_cnt), 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_pair_cnt", 32'(pair_cnt), 32'd3);
    chk("bp_pairs_seen", 32'(pairs_seen), 32'd3);

    // Error paths: rd_err in CAP_A, silence in CAP_B, saturation
    en = 1'b0; exp_err = 0; vc0 = valid_cycles;
    for (int i = 0; i < 20; i++) begin
      while (fifo_count < 4'd2) write_word($urandom);
      fail_is_err = 1'b1; fail_seq = rd_seq; en = 1'b1;
      wait_busy(1'b1, "erra_start");
      en = 1'b0;
      @(negedge clk);
      chk("erra_rd_en_low", 32'(rd_en), 32'd0);
      wait_busy(1'b0, "erra_idle");
      exp_err = (exp_err < 15) ? exp_err + 1 : 15;
      chk("erra_err_cnt", 32'(err_cnt), 32'(exp_err));
      fail_is_err = 1'b0; fail_seq = rd_seq + 1; en = 1'b1;
      wait_busy(1'b1, "errb_start");
      en = 1'b0;
      wait_busy(1'b0, "errb_idle");
      void'(exp_q.pop_front());
      exp_err = (exp_err < 15) ? exp_err + 1 : 15;
      chk("errb_err_cnt", 32'(err_cnt), 32'(exp_err));
    end
    fail_seq = -1;
    chk("err_saturated", 32'(err_cnt), 32'd15);
    chk("err_no_valid", 32'(valid_cycles - vc0), 32'd0);
    chk("err_pair_cnt_kept", 32'(pair_cnt), 32'd3);

    // Reset asserted in CAP_B
    while (fifo_count < 4'd2) write_word($urandom);
    en = 1'b1;
    wait_busy(1'b1, "rcb_start");
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rcb_in_capb", 32'({busy, out_valid, rd_en}), 32'b100);
    reset = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("rcb_rd_en", 32'(rd_en), 32'd0);
    chk("rcb_out_valid", 32'(out_valid), 32'd0);
    chk("rcb_busy", 32'(busy), 32'd0);
    chk("rcb_pair_cnt", 32'(pair_cnt), 32'd0);
    chk("rcb_err_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0; flush = 1'b0;
    exp_q.delete();
    @(negedge clk);

    // Full drain of 8 words
    for (int i = 1; i <= 8; i++) write_word(32'(i));
    chk("drain_full", 32'(fifo_count), 32'd8);
    e0 = err_resp; base = pairs_seen; en = 1'b1;
    wait_pairs(base + 4, 100, "drain_pairs");
    chk("drain_pair_cnt", 32'(pair_cnt), 32'd4);
    chk("drain_fifo_empty", 32'(fifo_count), 32'd0);
    chk("drain_no_rd_err", 32'(err_resp - e0), 32'd0);

    // Streaming until pair_cnt wraps after 256 pairs
    for (int i = 0; i < 504; i++) begin
      guard = 0;
      while (fifo_count >= 4'd7 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      write_word($urandom);
    end
    wait_pairs(base + 256, 3000, "wrap_pairs");
    chk("wrap_pair_cnt", 32'(pair_cnt), 32'd0);
    chk("wrap_no_rd_err", 32'(err_resp - e0), 32'd0);
    chk("wrap_err_cnt", 32'(err_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
